racetrack_lim_ctrl: RTL and testbench
=====================================

Name: racetrack_lim_ctrl

Overview:
- Sequencing controller between the core-side load/store/LIM request port and a single-access-port racetrack memory array.
- Accepts one request at a time over a req/gnt handshake.
- Shifts the track so the addressed domain sits under the access port, then runs the read, write or logic-in-memory (LIM) phase. Returns a single-cycle response pulse.
- Tracks the current track position so consecutive accesses shift only by the address delta.

Parameters:
- DATA_W, 32, data word width.
- N_DOMAINS, 64, domains per track. Must be a power of 2, at least 2. ADDR_W = $clog2(N_DOMAINS).
- RD_CYCLES, 1, cycles rd_en_o is held per read or LIM access. Minimum 1.
- WR_CYCLES, 1, cycles wr_en_o is held per write. Minimum 1.
- WAIT_LIM_CYCLES, 2, post-access wait before LIM result capture. Default comes from the shared package.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_i, in, 1: request valid.
- gnt_o, out, 1: request accepted this cycle.
- addr_i, in, ADDR_W: target domain index.
- we_i, in, 1: 1 = write, 0 = read or LIM.
- funct_i, in, 8: LIM function code. FUNCT_NONE = plain read/write.
- wdata_i, in, DATA_W: write data, or LIM operand.
- rvalid_o, out, 1: response pulse.
- rdata_o, out, DATA_W: read or LIM result, valid with rvalid_o.
- err_o, out, 1: error flag, valid with rvalid_o.
- sh_en_o, out, 1: shift track one domain this cycle.
- sh_dir_o, out, 1: 1 = toward higher index, 0 = lower.
- rd_en_o, out, 1: array read or LIM-evaluate strobe.
- wr_en_o, out, 1: array write strobe.
- arr_funct_o, out, 8: function code driven to the array.
- arr_wdata_o, out, DATA_W: data or operand driven to the array.
- arr_rdata_i, in, DATA_W: array read or LIM result.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE; pos = 0.
  - All outputs 0, including rdata_o, arr_funct_o and arr_wdata_o.
  - Reset mid-operation aborts the operation immediately. No response is issued. pos is forced to 0 regardless of the physical track; the array is reset alongside.
- States: IDLE, SHIFT, ACCESS, LIM_WAIT, RESP.
- IDLE:
  - gnt_o = req_i, combinational. Only IDLE grants.
  - On req_i, capture addr, we, funct and wdata into registers.
- Next state after a grant:
  - Illegal request (funct not one of NONE/XOR/AND/OR/NAND/NOR/XNOR, or we_i = 1 with funct != NONE): go to RESP with err = 1. No array strobes.
  - Otherwise, addr != pos: go to SHIFT.
  - Otherwise: go to ACCESS.
- SHIFT:
  - sh_en_o = 1 and sh_dir_o = (addr > pos) each cycle.
  - pos steps ±1 per cycle. Exactly |addr - pos| cycles.
  - The track is linear: no wrap, no shortest-path reversal.
  - Leave for ACCESS when pos reaches addr.
- ACCESS:
  - arr_funct_o and arr_wdata_o hold the captured values.
  - Write: wr_en_o = 1 for WR_CYCLES cycles, then RESP.
  - Read or LIM: rd_en_o = 1 for RD_CYCLES cycles.
  - Plain read: capture arr_rdata_i on the last ACCESS cycle, then RESP.
  - LIM: go to LIM_WAIT.
- LIM_WAIT:
  - No strobes; arr_funct_o is still held.
  - Lasts WAIT_LIM_CYCLES cycles. Capture arr_rdata_i on the last cycle, then RESP.
- RESP:
  - rvalid_o = 1 for exactly one cycle. rdata_o = captured data (0 for writes and errors). err_o as set.
  - Return to IDLE; the next grant is possible in the following cycle.
  - rdata_o and err_o hold their values until the next RESP.
- Latency, counted as cycles from the grant edge to the rvalid_o cycle:
  - Read: d + RD_CYCLES + 1, where d = |addr - pos|.
  - Write: d + WR_CYCLES + 1.
  - LIM: d + RD_CYCLES + WAIT_LIM_CYCLES + 1.
  - Error: 1.
- Boundaries:
  - addr = pos: zero SHIFT cycles.
  - addr = 0 or N_DOMAINS-1: full-length shift is allowed.
  - req_i while busy: gnt_o = 0 and the request is held by the requester.
  - Strobe exclusivity: sh_en_o, rd_en_o and wr_en_o are never high together.

Decomposition:
- Shared package (racetrack_defines) holds:
  - WAIT_LIM_CYCLES and the FUNCT_* codes;
  - a ctrl_state_t enum;
  - a funct_is_valid() function.
- One sub-module: racetrack_shift_unit. It owns pos, the distance/direction computation and sh_en_o/sh_dir_o, with a start/done handshake to the FSM.

Test Plan:
- Reset then read addr 5, pos 0, array returns 0xDEADBEEF → 5 SHIFT cycles, sh_dir_o = 1; rvalid_o at cycle 7; rdata_o = 0xDEADBEEF, err_o = 0.
- Write addr 5 then read addr 5 → the read has zero SHIFT cycles; read latency = 2.
- At pos 5, read addr 2 → 3 SHIFT cycles with sh_dir_o = 0; pos ends at 2.
- LIM FUNCT_XOR at addr 2 (pos 2), wdata 0x0F0F0F0F, array returns 0xF0F0F0F0 → arr_funct_o = 0x01; rd_en_o for 1 cycle; 2 wait cycles; rvalid_o at cycle 4 with 0xF0F0F0F0.
- funct_i = 0x07, or we_i = 1 with FUNCT_AND → rvalid_o at cycle 1, err_o = 1, no array strobes, pos unchanged.
- Read addr 63 from pos 0, rst_n dropped after 10 shift cycles, then read addr 1 → outputs 0 asynchronously, no rvalid_o; after reset the read addr 1 gets exactly 1 SHIFT cycle; gnt_o is held low during the busy period.

Source files
------------

// File: rtl/racetrack_lim_ctrl_pkg.sv
// Shared definitions for the racetrack LIM controller: function codes,
// controller state encoding and request legality check.
package racetrack_defines;

  // Default post-access settle time before a LIM result is valid.
  localparam int WAIT_LIM_CYCLES = 2;

  localparam logic [7:0] FUNCT_NONE = 8'h00;
  localparam logic [7:0] FUNCT_XOR  = 8'h01;
  localparam logic [7:0] FUNCT_AND  = 8'h02;
  localparam logic [7:0] FUNCT_OR   = 8'h03;
  localparam logic [7:0] FUNCT_NAND = 8'h04;
  localparam logic [7:0] FUNCT_NOR  = 8'h05;
  localparam logic [7:0] FUNCT_XNOR = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACCESS,
    ST_LIM_WAIT,
    ST_RESP
  } ctrl_state_t;

  // A request is legal when the code is known and LIM ops are reads only.
  function automatic logic funct_is_valid(input logic [7:0] funct, input logic we);
    logic known;
    known = (funct == FUNCT_NONE) || (funct == FUNCT_XOR)  || (funct == FUNCT_AND) ||
            (funct == FUNCT_OR)   || (funct == FUNCT_NAND) || (funct == FUNCT_NOR) ||
            (funct == FUNCT_XNOR);
    return known && (!we || (funct == FUNCT_NONE));
  endfunction

endpackage

// File: rtl/racetrack_lim_ctrl_shift.sv
// Track position tracker and shift sequencer. On start it walks the track
// one domain per cycle toward the target and flags done on the last step.
module racetrack_shift_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pos_o,
  output logic              done_o,
  output logic              sh_en_o,
  output logic              sh_dir_o
);

  logic              active_reg;
  logic [ADDR_W-1:0] target_reg;
  logic [ADDR_W-1:0] pos_reg;
  logic              dir_up;
  logic [ADDR_W-1:0] pos_step;

  // Direction and next position; linear track, so no wrap handling.
  always_comb begin
    dir_up   = (target_reg > pos_reg);
    pos_step = dir_up ? (pos_reg + 1'b1) : (pos_reg - 1'b1);
    sh_en_o  = active_reg;
    sh_dir_o = active_reg & dir_up;
    done_o   = active_reg && (pos_step == target_reg);
    pos_o    = pos_reg;
  end

  // Position register; the caller only starts when target differs from pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      target_reg <= '0;
      pos_reg    <= '0;
    end else if (active_reg) begin
      pos_reg <= pos_step;
      if (pos_step == target_reg) begin
        active_reg <= 1'b0;
      end
    end else if (start_i) begin
      active_reg <= 1'b1;
      target_reg <= target_i;
    end
  end

endmodule

// File: rtl/racetrack_lim_ctrl.sv
// Request sequencer for a single-port racetrack array: accepts one request,
// shifts the addressed domain under the port, runs read/write/LIM, responds.
module racetrack_lim_ctrl
  import racetrack_defines::*;
#(
  parameter int DATA_W          = 32,
  parameter int N_DOMAINS       = 64,
  parameter int RD_CYCLES       = 1,
  parameter int WR_CYCLES       = 1,
  parameter int WAIT_LIM_CYCLES = racetrack_defines::WAIT_LIM_CYCLES,
  localparam int ADDR_W         = $clog2(N_DOMAINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [7:0]        funct_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              sh_en_o,
  output logic              sh_dir_o,
  output logic              rd_en_o,
  output logic              wr_en_o,
  output logic [7:0]        arr_funct_o,
  output logic [DATA_W-1:0] arr_wdata_o,
  input  logic [DATA_W-1:0] arr_rdata_i
);

  localparam int CNT_W = 16;

  ctrl_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic [7:0]        funct_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic              req_load;
  logic              resp_load;
  logic              shift_start;
  logic              shift_done;
  logic [ADDR_W-1:0] pos;

  racetrack_shift_unit #(
    .ADDR_W (ADDR_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (shift_start),
    .target_i (addr_i),
    .pos_o    (pos),
    .done_o   (shift_done),
    .sh_en_o  (sh_en_o),
    .sh_dir_o (sh_dir_o)
  );

  // Next-state, phase counter, response data and array-side strobes.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    req_load    = 1'b0;
    resp_load   = 1'b0;
    shift_start = 1'b0;
    rd_en_o     = 1'b0;
    wr_en_o     = 1'b0;
    rvalid_o    = 1'b0;
    arr_funct_o = '0;
    arr_wdata_o = '0;
    // Grant is also masked by reset so every output reads 0 while held.
    gnt_o       = rst_n & req_i & (state_reg == ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (req_i) begin
          req_load = 1'b1;
          if (!funct_is_valid(funct_i, we_i)) begin
            state_next = ST_RESP;
            resp_load  = 1'b1;
            rdata_next = '0;
            err_next   = 1'b1;
          end else if (addr_i != pos) begin
            state_next  = ST_SHIFT;
            shift_start = 1'b1;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end

      ST_SHIFT: begin
        if (shift_done) begin
          state_next = ST_ACCESS;
          cnt_next   = '0;
        end
      end

      ST_ACCESS: begin
        arr_funct_o = funct_reg;
        arr_wdata_o = wdata_reg;
        if (we_reg) begin
          wr_en_o = 1'b1;
          if (cnt_reg == CNT_W'(WR_CYCLES - 1)) begin
            state_next = ST_RESP;
            resp_load  = 1'b1;
            rdata_next = '0;
            err_next   = 1'b0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          rd_en_o = 1'b1;
          if (cnt_reg == CNT_W'(RD_CYCLES - 1)) begin
            cnt_next = '0;
            if (funct_reg == FUNCT_NONE) begin
              state_next = ST_RESP;
              resp_load  = 1'b1;
              rdata_next = arr_rdata_i;
              err_next   = 1'b0;
            end else begin
              state_next = ST_LIM_WAIT;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      ST_LIM_WAIT: begin
        arr_funct_o = funct_reg;
        arr_wdata_o = wdata_reg;
        if (cnt_reg == CNT_W'(WAIT_LIM_CYCLES - 1)) begin
          state_next = ST_RESP;
          resp_load  = 1'b1;
          rdata_next = arr_rdata_i;
          err_next   = 1'b0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RESP: begin
        rvalid_o   = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    rdata_o = rdata_reg;
    err_o   = err_reg;
  end

  // State, request capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      funct_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (req_load) begin
        we_reg    <= we_i;
        funct_reg <= funct_i;
        wdata_reg <= wdata_i;
      end
      if (resp_load) begin
        rdata_reg <= rdata_next;
        err_reg   <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_racetrack_lim_ctrl.sv
// Directed bench for racetrack_lim_ctrl: per-transaction latency, shift
// count/direction, strobe counts, response data and a mid-shift reset.
module tb_racetrack_lim_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [5:0]  addr_i;
  logic        we_i;
  logic [7:0]  funct_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        sh_en_o;
  logic        sh_dir_o;
  logic        rd_en_o;
  logic        wr_en_o;
  logic [7:0]  arr_funct_o;
  logic [31:0] arr_wdata_o;
  logic [31:0] arr_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  racetrack_lim_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .funct_i     (funct_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .sh_en_o     (sh_en_o),
    .sh_dir_o    (sh_dir_o),
    .rd_en_o     (rd_en_o),
    .wr_en_o     (wr_en_o),
    .arr_funct_o (arr_funct_o),
    .arr_wdata_o (arr_wdata_o),
    .arr_rdata_i (arr_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request from grant to response; cycle 1 is the first cycle after the grant edge.
  task automatic run_txn(input string tag, input logic [5:0] addr, input logic we,
                         input logic [7:0] funct, input logic [31:0] wdata,
                         input logic [31:0] arr_data, input int exp_lat,
                         input int exp_sh, input logic exp_dir, input int exp_rd,
                         input int exp_wr, input logic [31:0] exp_rdata, input logic exp_err);
    int lat = -1;
    int nsh = 0, nrd = 0, nwr = 0, dir_bad = 0, excl = 0, gnt_busy = 0;
    logic [7:0]  funct_at_rd = '0;
    logic [31:0] wdata_at_wr = '0;
    logic [31:0] got_rdata = '0;
    logic        got_err = 1'b0;
    bit lim;
    lim = !we && (funct != 8'h00);
    @(negedge clk);
    addr_i      = addr;
    we_i        = we;
    funct_i     = funct;
    wdata_i     = wdata;
    req_i       = 1'b1;
    arr_rdata_i = lim ? 32'h0 : arr_data;
    #1;
    check_val({tag, ".gnt"}, 32'(gnt_o), 32'd1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (sh_en_o) begin
        nsh++;
        if (sh_dir_o !== exp_dir) dir_bad++;
      end
      if (rd_en_o) begin
        nrd++;
        funct_at_rd = arr_funct_o;
      end
      if (wr_en_o) begin
        nwr++;
        wdata_at_wr = arr_wdata_o;
      end
      if ((int'(sh_en_o) + int'(rd_en_o) + int'(wr_en_o)) > 1) excl++;
      if (gnt_o) gnt_busy++;
      if (rvalid_o) begin
        lat       = cyc;
        got_rdata = rdata_o;
        got_err   = err_o;
        break;
      end
      // LIM result only appears once the evaluate strobe has completed.
      if (lim && nrd > 0 && !rd_en_o) arr_rdata_i = arr_data;
    end
    req_i = 1'b0;
    check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, ".shifts"}, 32'(nsh), 32'(exp_sh));
    check_val({tag, ".dir_bad"}, 32'(dir_bad), 32'd0);
    check_val({tag, ".rd_cycles"}, 32'(nrd), 32'(exp_rd));
    check_val({tag, ".wr_cycles"}, 32'(nwr), 32'(exp_wr));
    check_val({tag, ".excl"}, 32'(excl), 32'd0);
    check_val({tag, ".gnt_busy"}, 32'(gnt_busy), 32'd0);
    check_val({tag, ".rdata"}, got_rdata, exp_rdata);
    check_val({tag, ".err"}, 32'(got_err), 32'(exp_err));
    if (exp_wr > 0) check_val({tag, ".arr_wdata"}, wdata_at_wr, wdata);
    if (lim && exp_rd > 0) check_val({tag, ".arr_funct"}, 32'(funct_at_rd), 32'(funct));
    @(negedge clk);
    check_val({tag, ".rvalid_pulse"}, 32'(rvalid_o), 32'd0);
    check_val({tag, ".rdata_hold"}, rdata_o, exp_rdata);
    $display("[TB] %s addr=%0d we=%0d funct=0x%02h lat=%0d shifts=%0d rdata=0x%08h err=%0d",
             tag, addr, we, funct, lat, nsh, got_rdata, got_err);
  endtask

  initial begin
    int nsh;
    rst_n       = 1'b0;
    req_i       = 1'b0;
    addr_i      = '0;
    we_i        = 1'b0;
    funct_i     = '0;
    wdata_i     = '0;
    arr_rdata_i = '0;
    repeat (3) @(negedge clk);
    check_val("rst.rvalid", 32'(rvalid_o), 32'd0);
    check_val("rst.rdata", rdata_o, 32'd0);
    check_val("rst.err", 32'(err_o), 32'd0);
    check_val("rst.strobes", {29'd0, sh_en_o, rd_en_o, wr_en_o}, 32'd0);
    check_val("rst.arr_funct", 32'(arr_funct_o), 32'd0);
    check_val("rst.arr_wdata", arr_wdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //       tag          addr we funct  wdata         arr_data      lat sh dir rd wr rdata         err
    run_txn("rd5",        6'd5,  0, 8'h00, 32'h0,        32'hDEADBEEF, 7,  5, 1, 1, 0, 32'hDEADBEEF, 0);
    run_txn("wr5",        6'd5,  1, 8'h00, 32'h12345678, 32'h0,        2,  0, 0, 0, 1, 32'h0,        0);
    run_txn("rd5b",       6'd5,  0, 8'h00, 32'h0,        32'hA5A5A5A5, 2,  0, 0, 1, 0, 32'hA5A5A5A5, 0);
    run_txn("rd2",        6'd2,  0, 8'h00, 32'h0,        32'h11223344, 5,  3, 0, 1, 0, 32'h11223344, 0);
    run_txn("lim_xor",    6'd2,  0, 8'h01, 32'h0F0F0F0F, 32'hF0F0F0F0, 4,  0, 0, 1, 0, 32'hF0F0F0F0, 0);
    run_txn("err_funct7", 6'd10, 0, 8'h07, 32'h0,        32'h99999999, 1,  0, 0, 0, 0, 32'h0,        1);
    run_txn("err_wr_and", 6'd10, 1, 8'h02, 32'h77777777, 32'h99999999, 1,  0, 0, 0, 0, 32'h0,        1);
    run_txn("rd2_pos",    6'd2,  0, 8'h00, 32'h0,        32'h00000055, 2,  0, 0, 1, 0, 32'h00000055, 0);
    run_txn("rd0",        6'd0,  0, 8'h00, 32'h0,        32'h00000000, 4,  2, 0, 1, 0, 32'h00000000, 0);
    run_txn("rd63_full",  6'd63, 0, 8'h00, 32'h0,        32'h63636363, 65, 63, 1, 1, 0, 32'h63636363, 0);
    run_txn("rd0_full",   6'd0,  0, 8'h00, 32'h0,        32'h13572468, 65, 63, 0, 1, 0, 32'h13572468, 0);

    // Mid-shift reset: start a long read, reset after 10 shift cycles.
    @(negedge clk);
    addr_i  = 6'd63;
    we_i    = 1'b0;
    funct_i = 8'h00;
    req_i   = 1'b1;
    #1;
    check_val("abort.gnt", 32'(gnt_o), 32'd1);
    @(posedge clk);
    nsh = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (sh_en_o) nsh++;
      if (gnt_o) check_val("abort.gnt_busy", 32'(gnt_o), 32'd0);
    end
    check_val("abort.shifts_before", 32'(nsh), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort.async_sh_en", 32'(sh_en_o), 32'd0);
    check_val("abort.async_rdata", rdata_o, 32'd0);
    check_val("abort.async_gnt", 32'(gnt_o), 32'd0);
    check_val("abort.async_rvalid", 32'(rvalid_o), 32'd0);
    repeat (2) @(negedge clk);
    check_val("abort.held_rvalid", 32'(rvalid_o), 32'd0);
    req_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort.post_rvalid", 32'(rvalid_o), 32'd0);
    $display("[TB] abort addr=63 shifts_before_reset=%0d", nsh);

    run_txn("rd1_after",  6'd1,  0, 8'h00, 32'h0,        32'hCAFEF00D, 3,  1, 1, 1, 0, 32'hCAFEF00D, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
